// File: rtl/instr_step_sequencer_if.sv
// Control bundle between the step sequencer and the DataPath: run/IR/handshake inputs
// and the per-step DataPath enables, register selects, opcode and status flags.
interface instr_step_sequencer_if #(
    parameter int NREG = 16,
    parameter int OPW  = 5
);
    logic            run;
    logic [31:0]     ir;
    logic            mem_ready;
    logic            alu_done;

    logic            PCout;
    logic            MARin;
    logic            incPC;
    logic            Zin;
    logic            PCin;
    logic            Read;
    logic            MDRin;
    logic            MDRout;
    logic            IRin;
    logic            Yin;
    logic            ZLowOut;
    logic            ZHighOut;
    logic            LOin;
    logic            HIin;

    logic [NREG-1:0] reg_in;
    logic [NREG-1:0] reg_out;
    logic [OPW-1:0]  opcode;
    logic            busy;
    logic            done;
    logic            halted;
    logic            illegal;

    modport master (
        input  run, ir, mem_ready, alu_done,
        output PCout, MARin, incPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin,
        output ZLowOut, ZHighOut, LOin, HIin,
        output reg_in, reg_out, opcode, busy, done, halted, illegal
    );

    modport slave (
        output run, ir, mem_ready, alu_done,
        input  PCout, MARin, incPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin,
        input  ZLowOut, ZHighOut, LOin, HIin,
        input  reg_in, reg_out, opcode, busy, done, halted, illegal
    );
endinterface

// File: rtl/instr_step_sequencer.sv
// Fetch/execute control-step FSM (T0..T6) driving DataPath enables, one step per clock.
// Optional macro SEQ_DIV_WAIT_EN: hold DIV in T4 until alu_done.
module instr_step_sequencer #(
    parameter int NREG = 16,
    parameter int OPW  = 5
) (
    input  logic                   clock,
    input  logic                   clear,
    instr_step_sequencer_if.master bus
);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T2   = 4'd3;
    localparam logic [3:0] S_T3   = 4'd4;
    localparam logic [3:0] S_T4   = 4'd5;
    localparam logic [3:0] S_T5   = 4'd6;
    localparam logic [3:0] S_T6   = 4'd7;
    localparam logic [3:0] S_HALT = 4'd8;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_MUL  = 5'b00011;
    localparam logic [4:0] OP_DIV  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_NOP  = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11010;

    // Enable vector bit positions, MSB first: PCout .. HIin
    localparam logic [13:0] EN_PCOUT  = 14'h2000;
    localparam logic [13:0] EN_MARIN  = 14'h1000;
    localparam logic [13:0] EN_INCPC  = 14'h0800;
    localparam logic [13:0] EN_ZIN    = 14'h0400;
    localparam logic [13:0] EN_PCIN   = 14'h0200;
    localparam logic [13:0] EN_READ   = 14'h0100;
    localparam logic [13:0] EN_MDRIN  = 14'h0080;
    localparam logic [13:0] EN_MDROUT = 14'h0040;
    localparam logic [13:0] EN_IRIN   = 14'h0020;
    localparam logic [13:0] EN_YIN    = 14'h0010;
    localparam logic [13:0] EN_ZLOW   = 14'h0008;
    localparam logic [13:0] EN_ZHIGH  = 14'h0004;
    localparam logic [13:0] EN_LOIN   = 14'h0002;
    localparam logic [13:0] EN_HIIN   = 14'h0001;

    function automatic logic is_rtype(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL: is_rtype = 1'b1;
            default:                                       is_rtype = 1'b0;
        endcase
    endfunction

    function automatic logic is_muldiv(input logic [4:0] op);
        case (op)
            OP_MUL, OP_DIV: is_muldiv = 1'b1;
            default:        is_muldiv = 1'b0;
        endcase
    endfunction

    function automatic logic [NREG-1:0] onehot(input logic [3:0] idx);
        logic [NREG-1:0] v;
        for (int i = 0; i < NREG; i++) begin
            v[i] = (idx == i[3:0]);
        end
        return v;
    endfunction

    logic [3:0]      state_r;
    logic [3:0]      next_state_s;
    logic [3:0]      after_done_s;
    logic            t1_wait_r;
    logic            halted_r;
    logic            illegal_r;
    logic            div_hold_s;
    logic            rtype_s;
    logic            muldiv_s;
    logic            legal_s;
    logic [4:0]      op_s;
    logic [3:0]      ra_s;
    logic [3:0]      rb_s;
    logic [3:0]      rc_s;
    logic [13:0]     en_s;
    logic [NREG-1:0] reg_in_s;
    logic [NREG-1:0] reg_out_s;
    logic [OPW-1:0]  opcode_s;
    logic            done_s;
    logic            unused_s;

    assign op_s     = bus.ir[31:27];
    assign ra_s     = bus.ir[26:23];
    assign rb_s     = bus.ir[22:19];
    assign rc_s     = bus.ir[18:15];
    assign rtype_s  = is_rtype(op_s);
    assign muldiv_s = is_muldiv(op_s);
    assign legal_s  = rtype_s | muldiv_s | (op_s == OP_NOP) | (op_s == OP_HALT);

`ifdef SEQ_DIV_WAIT_EN
    assign div_hold_s = (op_s == OP_DIV) && !bus.alu_done;
    assign unused_s   = ^bus.ir[14:0];
`else
    assign div_hold_s = 1'b0;
    assign unused_s   = ^{bus.ir[14:0], bus.alu_done};
`endif

    assign after_done_s = bus.run ? S_T0 : S_IDLE;

    // Next-state decode; the done step returns straight to T0 so there is no gap cycle
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (bus.run) next_state_s = S_T0;
                else         next_state_s = S_IDLE;
            end
            S_T0: next_state_s = S_T1;
            S_T1: begin
                if (bus.mem_ready) next_state_s = S_T2;
                else               next_state_s = S_T1;
            end
            S_T2: next_state_s = S_T3;
            S_T3: begin
                if (op_s == OP_NOP)           next_state_s = after_done_s;
                else if (rtype_s || muldiv_s) next_state_s = S_T4;
                else                          next_state_s = S_HALT;
            end
            S_T4: begin
                if (div_hold_s) next_state_s = S_T4;
                else            next_state_s = S_T5;
            end
            S_T5: begin
                if (muldiv_s) next_state_s = S_T6;
                else          next_state_s = after_done_s;
            end
            S_T6:    next_state_s = after_done_s;
            S_HALT:  next_state_s = S_HALT;
            default: next_state_s = S_IDLE;
        endcase
    end

    // Moore output decode from the current step and the latched IR fields
    always_comb begin
        en_s      = 14'h0000;
        reg_in_s  = '0;
        reg_out_s = '0;
        opcode_s  = '0;
        done_s    = 1'b0;
        case (state_r)
            S_T0: en_s = EN_PCOUT | EN_MARIN | EN_INCPC | EN_ZIN;
            S_T1: begin
                // PC is loaded only on the first T1 cycle; wait cycles keep the read open
                if (t1_wait_r) en_s = EN_READ | EN_MDRIN;
                else           en_s = EN_ZLOW | EN_PCIN | EN_READ | EN_MDRIN;
            end
            S_T2: en_s = EN_MDROUT | EN_IRIN;
            S_T3: begin
                if (rtype_s) begin
                    en_s      = EN_YIN;
                    reg_out_s = onehot(rb_s);
                end else if (muldiv_s) begin
                    en_s      = EN_YIN;
                    reg_out_s = onehot(ra_s);
                end else if (op_s == OP_NOP) begin
                    done_s = 1'b1;
                end else begin
                    done_s = 1'b0;
                end
            end
            S_T4: begin
                if (rtype_s) begin
                    en_s      = EN_ZIN;
                    reg_out_s = onehot(rc_s);
                    opcode_s  = OPW'(op_s);
                end else if (muldiv_s) begin
                    en_s      = EN_ZIN;
                    reg_out_s = onehot(rb_s);
                    opcode_s  = OPW'(op_s);
                end else begin
                    en_s = 14'h0000;
                end
            end
            S_T5: begin
                if (rtype_s) begin
                    en_s     = EN_ZLOW;
                    reg_in_s = onehot(ra_s);
                    done_s   = 1'b1;
                end else if (muldiv_s) begin
                    en_s = EN_ZLOW | EN_LOIN;
                end else begin
                    en_s = 14'h0000;
                end
            end
            S_T6: begin
                en_s   = EN_ZHIGH | EN_HIIN;
                done_s = 1'b1;
            end
            default: en_s = 14'h0000;
        endcase
    end

    // Step register, first-T1-cycle tracker and sticky halt/illegal flags
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_r   <= S_IDLE;
            t1_wait_r <= 1'b0;
            halted_r  <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            t1_wait_r <= (state_r == S_T1);
            halted_r  <= halted_r | ((state_r == S_T3) && (op_s == OP_HALT));
            illegal_r <= illegal_r | ((state_r == S_T3) && !legal_s);
        end
    end

    assign {bus.PCout, bus.MARin, bus.incPC, bus.Zin, bus.PCin, bus.Read, bus.MDRin,
            bus.MDRout, bus.IRin, bus.Yin, bus.ZLowOut, bus.ZHighOut, bus.LOin, bus.HIin} = en_s;
    assign bus.reg_in  = reg_in_s;
    assign bus.reg_out = reg_out_s;
    assign bus.opcode  = opcode_s;
    assign bus.done    = done_s;
    assign bus.busy    = (state_r != S_IDLE) && (state_r != S_HALT);
    assign bus.halted  = halted_r;
    assign bus.illegal = illegal_r;

endmodule
